// File: rtl/register_file_2r1w_pkg.sv
// Shared widths, types and constants for the 2-read/1-write register file.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NREGS    = 32;
  localparam int RF_RD_PORTS = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  localparam rf_addr_t RF_ZERO_REG = 5'd0;

  typedef struct packed {
    logic     en;
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;
endpackage

// File: rtl/register_file_2r1w_if.sv
// Decode/writeback side bundle of the register file: two read ports, one write port.
// RF_BYPASS_EN does not change this interface.
interface register_file_2r1w_if;
  import rf_pkg::*;

  rf_addr_t address_a;
  rf_data_t data_a;
  rf_addr_t address_b;
  rf_data_t data_b;
  logic     wr_en;
  rf_addr_t wr_address;
  rf_data_t wr_data;

  modport master (
    output address_a, address_b, wr_en, wr_address, wr_data,
    input  data_a, data_b
  );
  modport slave (
    input  address_a, address_b, wr_en, wr_address, wr_data,
    output data_a, data_b
  );
endinterface

// File: rtl/register_file_2r1w_read_port.sv
// One combinational read port: array mux, zero-register/reset force and,
// when RF_BYPASS_EN is defined, same-cycle forwarding of the pending write.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NREGS  = RF_NREGS
) (
  input  logic                         reset,
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  rf_addr_t                     addr,
`ifdef RF_BYPASS_EN
  input  rf_wr_t                       wr,
`endif
  output rf_data_t                     data
);
  always_comb begin
    data = regs[addr];
`ifdef RF_BYPASS_EN
    if (wr.en && wr.addr == addr) data = wr.data;
`endif
    // Reset gates the bypass too, since writes are ignored while reset is low.
    if (!reset || addr == RF_ZERO_REG) data = '0;
  end
endmodule

// File: rtl/register_file_2r1w.sv
// 32x32 register file, two combinational reads, one synchronous write, r0 hardwired zero.
// Define RF_BYPASS_EN for write-through forwarding on the read ports.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREGS  = RF_NREGS
) (
  input  logic                 clk,
  input  logic                 reset,
  register_file_2r1w_if.slave  bus
);
  logic [NREGS-1:0][DATA_W-1:0]      regs;
  rf_addr_t [RF_RD_PORTS-1:0]        rd_addr;
  rf_data_t [RF_RD_PORTS-1:0]        rd_data;
  rf_wr_t                            wr;
  logic [ADDR_W-1:0]                 wr_idx;

  assign wr      = {bus.wr_en, bus.wr_address, bus.wr_data};
  assign wr_idx  = wr.addr;
  assign rd_addr = {bus.address_b, bus.address_a};

  assign bus.data_a = rd_data[0];
  assign bus.data_b = rd_data[1];

  // Entry 0 is only ever cleared, so it stays zero in storage as well.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs <= '0;
    else if (wr.en && wr.addr != RF_ZERO_REG) regs[wr_idx] <= wr.data;
  end

  for (genvar p = 0; p < RF_RD_PORTS; p++) begin : g_rd
    rf_read_port #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rd (
      .reset (reset),
      .regs  (regs),
      .addr  (rd_addr[p]),
`ifdef RF_BYPASS_EN
      .wr    (wr),
`endif
      .data  (rd_data[p])
    );
  end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: vector table plus hand sequences for
// bypass and asynchronous reset; expectations follow RF_BYPASS_EN when defined.
module tb_register_file_2r1w;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  register_file_2r1w_if bus ();

  register_file_2r1w dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     wr_en;
    rf_addr_t wr_address;
    rf_data_t wr_data;
    rf_addr_t addr_a;
    rf_addr_t addr_b;
    rf_data_t exp_a;
    rf_data_t exp_b;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input rf_data_t act, input rf_data_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input rf_addr_t a, input rf_data_t d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_address = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    // Values are what the array holds after the vector's edge (reads sampled #1 after it).
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd5,  32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd3,  5'd31, 32'h12345678, 32'hA5A5A5A5};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4] = '{1'b0, 5'd6,  32'h11111111, 5'd6,  5'd6,  32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd5,  32'h00000001, 32'h00000001};
    vecs[6] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd3,  32'hA5A5A5A5, 32'h12345678};
    vecs[7] = '{1'b1, 5'd1,  32'h80000000, 5'd1,  5'd31, 32'h80000000, 32'hA5A5A5A5};

    bus.address_a = '0; bus.address_b = '0;
    bus.wr_en = 1'b0; bus.wr_address = '0; bus.wr_data = '0;

    // Power-on reset: every address reads zero on both ports.
    #12;
    for (int i = 0; i < 32; i++) begin
      bus.address_a = rf_addr_t'(i); bus.address_b = rf_addr_t'(31 - i);
      #1;
      check("por_a", bus.data_a, 32'h0);
      check("por_b", bus.data_b, 32'h0);
    end
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_en = vecs[i].wr_en; bus.wr_address = vecs[i].wr_address;
      bus.wr_data = vecs[i].wr_data;
      bus.address_a = vecs[i].addr_a; bus.address_b = vecs[i].addr_b;
      @(posedge clk); #1;
      check($sformatf("vec%0d_a", i), bus.data_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), bus.data_b, vecs[i].exp_b);
    end
    bus.wr_en = 1'b0;

    // Bypass: pending write to r7 observed before the edge only with forwarding.
    write_reg(5'd7, 32'h77777777);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_address = 5'd7; bus.wr_data = 32'hCAFEF00D;
    bus.address_a = 5'd7; bus.address_b = 5'd0;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_pre_a", bus.data_a, 32'hCAFEF00D);
`else
    check("bypass_pre_a", bus.data_a, 32'h77777777);
`endif
    check("bypass_pre_b_r0", bus.data_b, 32'h0);
    @(posedge clk); #1;
    check("bypass_post_a", bus.data_a, 32'hCAFEF00D);

    // Write to r0 with r0 on both ports: never forwarded.
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_address = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    bus.address_a = 5'd0; bus.address_b = 5'd0;
    #1;
    check("r0_pre_a", bus.data_a, 32'h0);
    @(posedge clk); #1;
    check("r0_post_b", bus.data_b, 32'h0);

    // Async reset between edges, write attempted while held, mid-cycle release.
    @(negedge clk);
    bus.wr_en = 1'b0; bus.address_a = 5'd7; bus.address_b = 5'd3;
    #1;
    check("pre_rst_a", bus.data_a, 32'hCAFEF00D);
    check("pre_rst_b", bus.data_b, 32'h12345678);
    #1 reset = 1'b0;
    #1;
    check("async_rst_a", bus.data_a, 32'h0);
    check("async_rst_b", bus.data_b, 32'h0);
    bus.wr_en = 1'b1; bus.wr_address = 5'd9; bus.wr_data = 32'h99999999;
    bus.address_a = 5'd9;
    #1;
    check("rst_bypass_blocked", bus.data_a, 32'h0);
    @(posedge clk); #1;
    check("rst_write_a", bus.data_a, 32'h0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("release_r9", bus.data_a, 32'h0);
    check("release_r3", bus.data_b, 32'h0);
    write_reg(5'd9, 32'h99999999);
    check("post_release_w", bus.data_a, 32'h99999999);

    // Preload every register, then hold reset and sweep all addresses.
    for (int i = 1; i < 32; i++) write_reg(rf_addr_t'(i), 32'h100 + i);
    bus.address_a = 5'd17; bus.address_b = 5'd31;
    #1;
    check("preload_a", bus.data_a, 32'h111);
    check("preload_b", bus.data_b, 32'h11F);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.address_a = rf_addr_t'(i); bus.address_b = rf_addr_t'(31 - i);
      #1;
      check("sweep_a", bus.data_a, 32'h0);
      check("sweep_b", bus.data_b, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
